// File: rtl/uart_pkg.sv
// Shared definitions for the UART timer scheduler: FSM state encoding and
// the helper that sizes requester index fields.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // A single requester still needs a 1-bit index field.
    function automatic int req_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_load_timer.sv
// Loadable down-counter shared by all UART timing requesters; it reports
// zero so the scheduler can decide between expiry and another decrement.
module uart_load_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load takes precedence; the zero guard keeps the count from wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/uart_timer_sched.sv
// Round-robin owner of the single UART timeout counter: grants one
// requester at a time, runs its count and pulses expired back to it.
module uart_timer_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    input  logic [NUM_REQ-1:0]       cancel,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       expired,
    output logic                     busy
);

    localparam int REQ_IDX_W = req_idx_w(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    sched_state_e         state_q;
    logic [REQ_IDX_W-1:0] owner_q;
    logic [REQ_IDX_W-1:0] ptr_q;
    logic [REQ_IDX_W-1:0] ptr_d;
    logic [REQ_IDX_W-1:0] winner;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   expired_q;
    logic                 found;
    logic                 zero;
    logic                 load;
    logic                 dec_en;
    logic                 own_cancel;
    logic [CNT_W-1:0]     load_val;

    // Search upward from the pointer, wrapping, for the first pending request.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = REQ_IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = winner + REQ_IDX_W'(1);
        if (int'(winner) == NUM_REQ - 1) begin
            ptr_d = '0;
        end
    end

    assign load_val   = req_count[int'(winner)*CNT_W +: CNT_W];
    assign own_cancel = cancel[owner_q];
    assign load       = (state_q == IDLE) && found;
    assign dec_en     = (state_q == RUN) && !own_cancel;

    uart_load_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(load_val),
        .dec_en  (dec_en),
        .zero    (zero)
    );

    // Cancel is checked before zero so a coinciding cancel suppresses expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            expired_q <= '0;
        end else begin
            expired_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        owner_q <= winner;
                        gnt_q   <= ONE_HOT0 << winner;
                        ptr_q   <= ptr_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (own_cancel) begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (zero) begin
                        expired_q <= ONE_HOT0 << owner_q;
                        gnt_q     <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign expired = expired_q;
    assign busy    = |gnt_q;

endmodule

// File: tb/tb_uart_timer_sched.sv
// Self-checking bench for uart_timer_sched: directed vector table, a
// randomized phase against a grant-lifetime model, and a mid-run reset.
module tb_uart_timer_sched;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_count;
    logic [NUM_REQ-1:0]       cancel;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       expired;
    logic                     busy;

    int checks   = 0;
    int failures = 0;

    // Model state: who owns the timer and how many grant cycles remain.
    int               mOwner;
    int               mLeft;
    int               mPtr;
    logic [NUM_REQ-1:0] mGnt;
    logic [NUM_REQ-1:0] mExp;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [1:0]  cancel;
        logic [1:0]  expGnt;
        logic [1:0]  expExp;
    } vec_t;

    vec_t vecQ[$];

    uart_timer_sched #(
        .NUM_REQ(NUM_REQ),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_count(req_count),
        .cancel   (cancel),
        .gnt      (gnt),
        .expired  (expired),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mOwner = -1;
        mLeft  = 0;
        mPtr   = 0;
        mGnt   = '0;
        mExp   = '0;
    endtask

    // A grant of count C lasts C+1 cycles, then expires unless cancelled.
    task automatic modelStep(input logic [1:0] r, input logic [15:0] a,
                             input logic [15:0] b, input logic [1:0] c);
        int cnt[2];
        int i;
        cnt[0] = int'(a);
        cnt[1] = int'(b);
        mExp = '0;
        if (mOwner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (mPtr + k) % NUM_REQ;
                if (mOwner < 0 && r[i]) begin
                    mOwner = i;
                    mLeft  = cnt[i] + 1;
                    mPtr   = (i + 1) % NUM_REQ;
                end
            end
        end else if (c[mOwner]) begin
            mOwner = -1;
        end else begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mExp[mOwner] = 1'b1;
                mOwner = -1;
            end
        end
        mGnt = '0;
        if (mOwner >= 0) begin
            mGnt[mOwner] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] a,
                                 input logic [15:0] b, input logic [1:0] c);
        req       = r;
        req_count = {b, a};
        cancel    = c;
        modelStep(r, a, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eg,
                               input logic [1:0] ee);
        checks++;
        if (gnt !== eg) begin
            failures++;
            $display("[TB] FAIL %s gnt got=%b exp=%b", name, gnt, eg);
        end
        checks++;
        if (expired !== ee) begin
            failures++;
            $display("[TB] FAIL %s expired got=%b exp=%b", name, expired, ee);
        end
        checks++;
        if (busy !== (|eg)) begin
            failures++;
            $display("[TB] FAIL %s busy got=%b exp=%b", name, busy, |eg);
        end
    endtask

    task automatic addVec(input logic [1:0] r, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] c,
                          input logic [1:0] eg, input logic [1:0] ee);
        vecQ.push_back('{r, a, b, c, eg, ee});
    endtask

    initial begin
        logic [1:0]  r;
        logic [1:0]  c;
        logic [15:0] a;
        logic [15:0] b;

        rst_n     = 1'b0;
        req       = '0;
        req_count = '0;
        cancel    = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 2'b00, 2'b00);
        rst_n = 1'b1;

        // Two requesters held high with count 2: grants alternate 0,1,0,1.
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b00, 2'b01);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b00, 2'b10);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b01, 2'b00);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b00, 2'b01);
        addVec(2'b11, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd2, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd2, 16'd2, 2'b00, 2'b00, 2'b10);
        addVec(2'b00, 16'd2, 16'd2, 2'b00, 2'b00, 2'b00);
        // Single requester 0, count 3: four grant cycles, then expiry.
        addVec(2'b01, 16'd3, 16'd0, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd3, 16'd0, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd3, 16'd0, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd3, 16'd0, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd3, 16'd0, 2'b00, 2'b00, 2'b01);
        addVec(2'b00, 16'd3, 16'd0, 2'b00, 2'b00, 2'b00);
        // Count 0 gives one grant cycle; a non-owner cancel is ignored.
        addVec(2'b01, 16'd0, 16'd0, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd0, 16'd0, 2'b10, 2'b00, 2'b01);
        addVec(2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        // Cancel coinciding with counter zero suppresses expiry.
        addVec(2'b10, 16'd0, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd0, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd0, 16'd2, 2'b00, 2'b10, 2'b00);
        addVec(2'b00, 16'd0, 16'd2, 2'b10, 2'b00, 2'b00);
        addVec(2'b00, 16'd0, 16'd2, 2'b00, 2'b00, 2'b00);
        // Early cancel of requester 1 hands the timer to pending requester 0.
        addVec(2'b10, 16'd1, 16'd10, 2'b00, 2'b10, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b00, 2'b10, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b00, 2'b10, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b00, 2'b10, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b00, 2'b10, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b10, 2'b00, 2'b00);
        addVec(2'b01, 16'd1, 16'd10, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd1, 16'd10, 2'b00, 2'b01, 2'b00);
        addVec(2'b00, 16'd1, 16'd10, 2'b00, 2'b00, 2'b01);
        addVec(2'b00, 16'd1, 16'd10, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(vecQ[i].req, vecQ[i].c0, vecQ[i].c1, vecQ[i].cancel);
            checkOutput($sformatf("vec%0d", i), vecQ[i].expGnt, vecQ[i].expExp);
        end

        for (int n = 0; n < 400; n++) begin
            r = 2'($urandom_range(0, 3));
            a = 16'($urandom_range(0, 5));
            b = 16'($urandom_range(0, 5));
            c = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            applyStimulus(r, a, b, c);
            checkOutput($sformatf("rand%0d", n), mGnt, mExp);
        end

        // Flush any run left by the random phase before the reset sequence.
        applyStimulus(2'b00, 16'd0, 16'd0, 2'b11);
        checkOutput("flush0", mGnt, mExp);
        applyStimulus(2'b00, 16'd0, 16'd0, 2'b00);
        checkOutput("flush1", mGnt, mExp);

        applyStimulus(2'b01, 16'd50, 16'd0, 2'b00);
        checkOutput("long_grant", 2'b01, 2'b00);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(2'b00, 16'd50, 16'd0, 2'b00);
            checkOutput($sformatf("long_run%0d", n), 2'b01, 2'b00);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", 2'b00, 2'b00);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b11, 16'd3, 16'd3, 2'b00);
        checkOutput("post_reset_ptr", 2'b01, 2'b00);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(2'b00, 16'd3, 16'd3, 2'b00);
            checkOutput($sformatf("post_reset%0d", n), mGnt, mExp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_timer_sched.md
Name: uart_timer_sched

Overview:
Round-robin scheduler that shares one loadable down-counter timer between several UART timing requesters, e.g. RX character timeout, TX break generation and the inter-frame idle gap. Each requester asks for a timeout of a given length. The block grants the single timer to one requester at a time, runs it, and returns a one-cycle expiry pulse to that owner. It sits between the TX/RX control FSMs and the timer resource, so the design needs only one counter.

Parameters:
NUM_REQ, 2, number of requesters (≥2).
CNT_W, 16, width of each requested count and of the internal counter.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; held until that requester's gnt is seen
req_count  in  NUM_REQ*CNT_W  packed counts; slice i = [i*CNT_W +: CNT_W]; sampled only in the arbitration cycle
cancel  in  NUM_REQ  abort request; acts only when bit = current owner
gnt  out  NUM_REQ  one-hot (or zero) owner indication, registered
expired  out  NUM_REQ  one-cycle pulse to owner on timeout, registered
busy  out  1  high while timer owned (= |gnt)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: gnt=0, expired=0, busy=0, state=IDLE, counter=0, round-robin pointer=0 (requester 0 highest priority).
- The FSM has two states, IDLE and RUN.
- IDLE:
  - If req≠0, select the first set bit searching from pointer upward, wrapping mod NUM_REQ.
  - On the next edge: owner←winner, counter←req_count[winner], gnt[winner]←1, pointer←(winner+1) mod NUM_REQ, state←RUN.
  - If req=0, stay in IDLE with no change.
- RUN, evaluated in priority order:
  1. cancel[owner]=1: next edge gives gnt←0, state←IDLE, no expired pulse.
  2. Else if counter==0: next edge gives expired[owner]←1 for one cycle, gnt←0, state←IDLE.
  3. Else counter←counter−1.
- Timing: if arbitration happens in cycle t with count C, gnt is high for cycles t+1..t+C+1 (C+1 cycles) and expired is high in cycle t+C+2. C=0 is legal and gives gnt for 1 cycle, then expired.
- The expiry cycle is itself an IDLE cycle and may arbitrate, so back-to-back grants have gnt low for exactly 1 cycle between them.
- Requesters must drop req no later than the cycle expired is seen. A req still high in the IDLE cycle after that is treated as a new request.
- In RUN, req and req_count changes from any requester are ignored, including the owner dropping req. Only cancel ends a run early.
- cancel on a non-owner bit, or in IDLE, is ignored.
- A cancel that coincides with counter==0 wins: no expired pulse.
- expired is never asserted for more than one bit or for more than one cycle.
- Reset asserted mid-RUN immediately clears all outputs. No pulse is generated on release.
- The counter is unsigned CNT_W bits. The decrement never wraps because counter==0 exits RUN.

Decomposition:
- Shared package (uart_pkg):
  - state encoding IDLE/RUN;
  - helper constant REQ_IDX_W = $clog2(NUM_REQ), minimum 1.
- Sub-module uart_load_timer:
  - ports: load, load_val[CNT_W], dec_en, zero;
  - loadable down-counter with asynchronous active-low reset.
- Arbitration and the FSM stay in uart_timer_sched.

Test Plan:
1. Only req[0] high with count 3 at cycle t → gnt=01 for t+1..t+4; expired=01 at t+5 only; busy mirrors gnt.
2. req=11, both counts 2, held and re-raised after each expiry → grant order 0,1,0,1; each gnt lasts 3 cycles; 1-cycle gap between grants.
3. req[1] count 10, cancel[1] pulsed 4 cycles after grant → gnt drops on the next edge; expired stays 0; req[0] pending is granted in that following IDLE cycle.
4. req[0] count 0 → gnt for exactly 1 cycle, expired[0] the next cycle; cancel[1] during the run has no effect.
5. cancel[owner] asserted in the same cycle the counter hits 0 (count 2, cancel at grant+2) → no expired pulse; FSM returns to IDLE.
6. rst_n pulled low mid-run with count 50 → gnt, expired and busy are 0 at once; after release, req=11 grants requester 0 first, showing the pointer was reset.
